// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load results onto the single regfile write port.
//   clk, reset            : clock and synchronous active-high reset
//   alu_valid/rd/data     : ALU result; it always wins and is never back-pressured
//   load_valid/ready/rd/data : load result handshake into an in-order queue
//   write/writeReg/writeData : registered regfile write port
//   busy                  : bit r set while a live queued load targets register r
// Optional build macro WB_BYPASS_EN: a load arriving when the queue is empty and the
// ALU is idle goes straight to the output stage instead of being enqueued.
module regfile_wb_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [DATAWIDTH-1:0] alu_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [4:0]           load_rd,
    input  logic [DATAWIDTH-1:0] load_data,
    output logic                 write,
    output logic [4:0]           writeReg,
    output logic [DATAWIDTH-1:0] writeData,
    output logic [31:0]          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     live;
    logic [4:0]           ent_rd [DEPTH];
    logic [DATAWIDTH-1:0] ent_data [DEPTH];
    logic                 alu_sel, empty, fire, pop, q_sel, push, bypass;

    assign load_ready = count != CW'(DEPTH);
    assign empty      = count == '0;
    assign alu_sel    = alu_valid && alu_rd != '0;
    assign fire       = load_valid && load_ready;
    // Any non-ALU cycle retires the head: a live head is written, a killed one just drops.
    assign pop        = !alu_sel && !empty;
    assign q_sel      = pop && live[rd_ptr];
`ifdef WB_BYPASS_EN
    assign bypass     = empty && !alu_sel && fire && load_rd != '0;
`else
    assign bypass     = 1'b0;
`endif
    // A same-cycle ALU write to the same register is younger, so that load is dropped.
    assign push       = fire && load_rd != '0 && !(alu_sel && alu_rd == load_rd) && !bypass;

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) busy[ent_rd[i]] = 1'b1;
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= load_rd;
            ent_data[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            live      <= '0;
            write     <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            // WAW kill; never collides with pop (needs !alu_sel) or push (free slot).
            for (int i = 0; i < DEPTH; i++)
                if (alu_sel && live[i] && ent_rd[i] == alu_rd) live[i] <= 1'b0;
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            write <= alu_sel || q_sel || bypass;
            if (alu_sel) begin
                writeReg  <= alu_rd;
                writeData <= alu_data;
            end else if (q_sel) begin
                writeReg  <= ent_rd[rd_ptr];
                writeData <= ent_data[rd_ptr];
            end else if (bypass) begin
                writeReg  <= load_rd;
                writeData <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: self-checking bench for regfile_wb_arbiter (vector table,
// hand sequences, and a write-order scoreboard).
module tb_regfile_wb_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, load_valid, load_ready, write;
    logic [4:0]    alu_rd, load_rd, writeReg;
    logic [DW-1:0] alu_data, load_data, writeData;
    logic [31:0]   busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATAWIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_data(load_data),
        .write(write), .writeReg(writeReg), .writeData(writeData), .busy(busy)
    );

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          av;
        logic [4:0]    ard;
        logic [DW-1:0] ad;
        logic          lv;
        logic [4:0]    lrd;
        logic [DW-1:0] ld;
        logic          ew;
        logic [4:0]    er;
        logic [DW-1:0] ed;
    } vec_t;

    wr_t  alu_q[$];
    wr_t  load_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic alu_pend = 1'b0;
    logic last_fire = 1'b0;
    vec_t vecs[8];
    int   nl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Drive one cycle of stimulus, record expected writes, then return inputs to idle.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        load_valid = lv; load_rd = lrd; load_data = ld;
        last_fire = lv && load_ready;
        if (av && ard != 5'd0) alu_q.push_back(wr_t'{ard, ad});
        if (last_fire && lrd != 5'd0 && !(av && ard == lrd)) load_q.push_back(wr_t'{lrd, ld});
        @(posedge clk);
        #1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        load_valid = 1'b0; load_rd = 5'd0; load_data = '0;
    endtask

    always @(posedge clk) alu_pend = alu_valid && alu_rd != 5'd0 && !reset;

    // ALU results land the cycle after they are driven; any other write must be the oldest surviving load.
    always @(negedge clk) begin
        if (mon_en) begin
            if (alu_pend) begin
                if (alu_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL alu_sb_empty: ALU write pending with no expectation");
                end else begin
                    mon_e = alu_q.pop_front();
                    check("alu_write", {write, writeReg, writeData}, {1'b1, mon_e.rd, mon_e.data});
                end
            end else if (write) begin
                if (load_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: reg %0d data 0x%0h, none expected", writeReg, writeData);
                end else begin
                    mon_e = load_q.pop_front();
                    check("load_write", {writeReg, writeData}, {mon_e.rd, mon_e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'h0000_1234};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'h0000_1234};
        vecs[2] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'h0000_1234};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd5,  32'h0000_1234};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h5A,   1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 5'd0,  32'h11,        1'b1, 5'd0, 32'h22,   1'b0, 5'd31, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 5'd7,  32'hC0DE,      1'b1, 5'd7, 32'hBAD,  1'b1, 5'd7,  32'hC0DE};
        vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd7,  32'hC0DE};

        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        load_valid = 1'b0; load_rd = 5'd0; load_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out", {write, writeReg, writeData}, 64'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_ready", load_ready, 1'b1);
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            @(negedge clk);
            check($sformatf("vec%0d_out", i), {write, writeReg, writeData}, {vecs[i].ew, vecs[i].er, vecs[i].ed});
            check($sformatf("vec%0d_busy", i), busy, 32'd0);
            check($sformatf("vec%0d_handshake", i), last_fire, vecs[i].lv);
        end

        cyc(1'b0, 5'd0, '0, 1'b1, 5'd3, 32'h77);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("lat_n1", {write, writeReg, writeData}, {1'b1, 5'd3, 32'h77});
        check("lat_busy3", busy[3], 1'b0);
        @(negedge clk);
        check("lat_n2", write, 1'b0);
`else
        check("lat_n1", write, 1'b0);
        check("lat_busy3", busy[3], 1'b1);
        @(negedge clk);
        check("lat_n2", {write, writeReg, writeData}, {1'b1, 5'd3, 32'h77});
`endif

        nl = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 5'(i + 1), 32'(32'h100 + i), nl < 5, 5'(10 + nl), 32'(32'hA0 + nl));
            if (last_fire) nl++;
        end
        @(negedge clk);
        check("bp_accepted", 64'(nl), 64'd4);
        check("bp_ready", load_ready, 1'b0);
        check("bp_busy", busy[14:10], 5'h0F);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 5'd0, '0, nl < 5, 5'(10 + nl), 32'(32'hA0 + nl));
            if (i == 0) check("bp_pop_no_ready", last_fire, 1'b0);
            if (last_fire) nl++;
            @(negedge clk);
            check($sformatf("bp_stream%0d", i), write, 1'b1);
        end
        check("bp_all_accepted", 64'(nl), 64'd5);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        check("bp_drained_write", write, 1'b0);
        check("bp_drained_busy", busy, 32'd0);
        check("bp_drained_ready", load_ready, 1'b1);

        cyc(1'b1, 5'd1, 32'h201, 1'b1, 5'd9, 32'hAAAA);
        cyc(1'b1, 5'd2, 32'h202, 1'b1, 5'd12, 32'hC0C0);
        @(negedge clk);
        check("waw_busy_before", {busy[12], busy[9]}, 2'b11);
        for (int i = 0; i < load_q.size(); i++)
            if (load_q[i].rd == 5'd9) begin
                load_q.delete(i);
                break;
            end
        cyc(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, '0);
        @(negedge clk);
        check("waw_busy_after", {busy[12], busy[9]}, 2'b10);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        check("waw_dead_pop", write, 1'b0);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        check("waw_next_live", {write, writeReg, writeData}, {1'b1, 5'd12, 32'hC0C0});
        @(negedge clk);
        check("waw_idle", write, 1'b0);

        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'(1 + i), 32'(32'h300 + i), 1'b1, 5'(20 + i), 32'(32'h400 + i));
        @(negedge clk);
        check("rst2_busy_before", busy[22:20], 3'b111);
        load_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst2_write", write, 1'b0);
        check("rst2_busy", busy, 32'd0);
        check("rst2_ready", load_ready, 1'b1);
        check("rst2_regdata", {writeReg, writeData}, 37'd0);
        repeat (6) @(negedge clk);

        check("sb_alu_drain", 64'(alu_q.size()), 64'd0);
        check("sb_load_drain", 64'(load_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
